control_ventilacion_alarma: RTL

- Supervisory FSM that sequences the cabin climate and alarm outputs from the temperature, presence and ignition inputs.
- Registers and synchronises the raw inputs, applies a threshold with hysteresis, and confirms over-temperature with a tick-based counter.
- Holds the alarm for a minimum time and publishes a 2-bit alert code, which the display path (BCD/7-segment mux) consumes.

---
 rtl/sistema_pkg.sv | 42 ++++
 rtl/divisor_tick.sv | 46 ++++
 rtl/control_ventilacion_alarma.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sistema_pkg.sv
// -----------------------------------------------------------------------------
// sistema_pkg
// Shared definitions for the cabin climate / alarm supervisor and the display
// path that consumes its alert code and tick.
//   - estado_t     : supervisor state encoding. It is also the alerta code
//                    (00 APAGADO, 01 NORMAL, 10 VENTILA, 11 ALARMA).
//   - *_DEF        : default thresholds and timing.
//   - ancho_contador(n) : bits needed to count 0..n-1. Never returns less
//                    than 1, so degenerate parameters still give a legal vector.
// -----------------------------------------------------------------------------
package sistema_pkg;

  typedef enum logic [1:0] {
    APAGADO = 2'b00,
    NORMAL  = 2'b01,
    VENTILA = 2'b10,
    ALARMA  = 2'b11
  } estado_t;

  localparam logic [1:0] ALERTA_APAGADO = 2'b00;
  localparam logic [1:0] ALERTA_NORMAL  = 2'b01;
  localparam logic [1:0] ALERTA_VENTILA = 2'b10;
  localparam logic [1:0] ALERTA_ALARMA  = 2'b11;

  // Temperatures are in degrees C and fit the 5-bit unsigned sensor range.
  localparam int unsigned T_ALTO_DEF     = 25;
  localparam int unsigned T_BAJO_DEF     = 22;
  localparam int unsigned T_CRIT_DEF     = 30;
  localparam int unsigned N_CONFIRM_DEF  = 3;
  localparam int unsigned ALARM_HOLD_DEF = 5;
  localparam int unsigned PRESCALE_DEF   = 50_000_000;

  function automatic int unsigned ancho_contador(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The alert code is the state encoding itself.
  function automatic logic [1:0] alerta_de(input estado_t s);
    return s;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// -----------------------------------------------------------------------------
// divisor_tick
// Free-running prescaler. It counts 0..PRESCALE-1. tick is high for one clk in
// the cycle the counter wraps back to 0. The supervisor uses it and so does the
// display mux scheduler.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous reset, active low
//   tick out registered one-cycle pulse, once every PRESCALE clk
// -----------------------------------------------------------------------------
module divisor_tick
  import sistema_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = ancho_contador(PRESCALE);
  localparam logic [CW-1:0] ULTIMO = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == ULTIMO) ? '0 : cnt_q + CW'(1);
    // tick is registered, so it is high exactly while the counter sits at 0
    // after a wrap.
    tick_d = (cnt_q == ULTIMO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/control_ventilacion_alarma.sv
// -----------------------------------------------------------------------------
// control_ventilacion_alarma
// Supervisory FSM for the cabin fan and the over-temperature alarm.
//   - presencia and ignicion pass through 2-flop synchronisers. temperatura
//     passes through two register stages. All decisions use only these
//     conditioned copies.
//   - Fan hysteresis: on at temp >= T_ALTO, off at temp <= T_BAJO.
//   - Over-temperature must hold for N_CONFIRM consecutive ticks before ALARMA.
//   - ALARMA lasts at least ALARM_HOLD ticks. Ignition-off does not cut it short.
//
// Build option:
//   ALARMA_INTERMITENTE_EN  When defined, alarma toggles on every tick while in
//                           ALARMA and starts at 1. When undefined, alarma is a
//                           steady 1 in ALARMA.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active low
//   temperatura  in   [4:0] unsigned degrees C
//   presencia    in   occupant present (asynchronous)
//   ignicion     in   ignition on (asynchronous)
//   ventilacion  out  fan enable
//   alarma       out  alarm enable
//   alerta       out  [1:0] 00 APAGADO, 01 NORMAL, 10 VENTILA, 11 ALARMA
//   estado       out  1 when the supervisor is not APAGADO
//   tick         out  prescaler pulse, shared with the display scheduler
//
// Latency from a pin change to the outputs is 4 clk: 2 for synchronisation,
// 1 for the state register and 1 for the output register. Tick waits add to
// this.
// -----------------------------------------------------------------------------
module control_ventilacion_alarma
  import sistema_pkg::*;
#(
  parameter int unsigned T_ALTO     = T_ALTO_DEF,     // fan-on threshold
  parameter int unsigned T_BAJO     = T_BAJO_DEF,     // fan-off threshold (< T_ALTO)
  parameter int unsigned T_CRIT     = T_CRIT_DEF,     // critical threshold (> T_ALTO)
  parameter int unsigned N_CONFIRM  = N_CONFIRM_DEF,  // hot ticks needed for ALARMA
  parameter int unsigned ALARM_HOLD = ALARM_HOLD_DEF, // minimum ALARMA ticks
  parameter int unsigned PRESCALE   = PRESCALE_DEF    // clk cycles per tick
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] temperatura,
  input  logic       presencia,
  input  logic       ignicion,
  output logic       ventilacion,
  output logic       alarma,
  output logic [1:0] alerta,
  output logic       estado,
  output logic       tick
);

  localparam logic [4:0] T_ALTO_C = 5'(T_ALTO);
  localparam logic [4:0] T_BAJO_C = 5'(T_BAJO);
  localparam logic [4:0] T_CRIT_C = 5'(T_CRIT);

  localparam int unsigned CFW = ancho_contador(N_CONFIRM + 1);
  localparam int unsigned HW  = ancho_contador(ALARM_HOLD + 1);
  localparam logic [CFW-1:0] N_CONFIRM_C  = CFW'(N_CONFIRM);
  localparam logic [HW-1:0]  ALARM_HOLD_C = HW'(ALARM_HOLD);

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  logic tick_w;

  divisor_tick #(
    .PRESCALE(PRESCALE)
  ) u_divisor_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick_w)
  );

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic       ign_m_q, ign_m_d, ign_s_q, ign_s_d;
  logic       pres_m_q, pres_m_d, pres_s_q, pres_s_d;
  logic [4:0] temp_m_q, temp_m_d, temp_s_q, temp_s_d;

  always_comb begin
    ign_m_d  = ignicion;
    ign_s_d  = ign_m_q;
    pres_m_d = presencia;
    pres_s_d = pres_m_q;
    // The two temperature stages keep the bus aligned with the 1-bit syncs.
    temp_m_d = temperatura;
    temp_s_d = temp_m_q;
  end

  // ---------------------------------------------------------------------------
  // Supervisor state and counters
  // ---------------------------------------------------------------------------
  estado_t        state_q, state_d;
  logic [CFW-1:0] confirm_q, confirm_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           entra_alarma;

  always_comb begin
    state_d = state_q;
    case (state_q)
      APAGADO: begin
        if (ign_s_q) state_d = NORMAL;
      end
      NORMAL: begin
        if (!ign_s_q)                              state_d = APAGADO;
        else if (confirm_q == N_CONFIRM_C)         state_d = ALARMA;
        else if (temp_s_q >= T_ALTO_C && pres_s_q) state_d = VENTILA;
      end
      VENTILA: begin
        // A temperature strictly between T_BAJO and T_ALTO falls through all
        // branches and keeps the fan on. This is the hysteresis band.
        if (!ign_s_q)                                state_d = APAGADO;
        else if (confirm_q == N_CONFIRM_C)           state_d = ALARMA;
        else if (temp_s_q <= T_BAJO_C || !pres_s_q)  state_d = NORMAL;
      end
      ALARMA: begin
        // Only the hold timer and a cooled sensor end the alarm. Ignition
        // only picks the exit state.
        if (hold_q == '0 && temp_s_q < T_CRIT_C) begin
          if (!ign_s_q)                                 state_d = APAGADO;
          else if (temp_s_q > T_BAJO_C && pres_s_q)     state_d = VENTILA;
          else                                          state_d = NORMAL;
        end
      end
      default: state_d = APAGADO;
    endcase
  end

  assign entra_alarma = (state_d == ALARMA) && (state_q != ALARMA);

  // The counters look at state_q, the state before the transition. A tick in
  // the same cycle as a transition is therefore charged to the old state.
  always_comb begin
    confirm_d = confirm_q;
    if (state_q == APAGADO) begin
      confirm_d = '0;
    end else if (tick_w) begin
      if (temp_s_q >= T_CRIT_C)
        confirm_d = (confirm_q == N_CONFIRM_C) ? confirm_q : confirm_q + CFW'(1);
      else
        confirm_d = '0;
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (entra_alarma)
      hold_d = ALARM_HOLD_C;
    else if (state_q == ALARMA && tick_w && hold_q != '0)
      hold_d = hold_q - HW'(1);
  end

`ifdef ALARMA_INTERMITENTE_EN
  // Blink phase. It is set on entry so the first alarm period is "on", and it
  // flips on every tick spent in ALARMA.
  logic blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (entra_alarma)
      blink_d = 1'b1;
    else if (state_q == ALARMA && tick_w)
      blink_d = ~blink_q;
  end
`endif

  // ---------------------------------------------------------------------------
  // Output register. It is decoded from the freshly registered state, so the
  // outputs follow one clk after the transition decision.
  // ---------------------------------------------------------------------------
  logic       vent_q, vent_d;
  logic       alarma_q, alarma_d;
  logic [1:0] alerta_q, alerta_d;
  logic       estado_q, estado_d;

  always_comb begin
    vent_d   = (state_q == VENTILA) || (state_q == ALARMA);
`ifdef ALARMA_INTERMITENTE_EN
    alarma_d = (state_q == ALARMA) && blink_q;
`else
    alarma_d = (state_q == ALARMA);
`endif
    alerta_d = alerta_de(state_q);
    estado_d = (state_q != APAGADO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ign_m_q   <= 1'b0;
      ign_s_q   <= 1'b0;
      pres_m_q  <= 1'b0;
      pres_s_q  <= 1'b0;
      temp_m_q  <= '0;
      temp_s_q  <= '0;
      state_q   <= APAGADO;
      confirm_q <= '0;
      hold_q    <= '0;
`ifdef ALARMA_INTERMITENTE_EN
      blink_q   <= 1'b0;
`endif
      vent_q    <= 1'b0;
      alarma_q  <= 1'b0;
      alerta_q  <= ALERTA_APAGADO;
      estado_q  <= 1'b0;
    end else begin
      ign_m_q   <= ign_m_d;
      ign_s_q   <= ign_s_d;
      pres_m_q  <= pres_m_d;
      pres_s_q  <= pres_s_d;
      temp_m_q  <= temp_m_d;
      temp_s_q  <= temp_s_d;
      state_q   <= state_d;
      confirm_q <= confirm_d;
      hold_q    <= hold_d;
`ifdef ALARMA_INTERMITENTE_EN
      blink_q   <= blink_d;
`endif
      vent_q    <= vent_d;
      alarma_q  <= alarma_d;
      alerta_q  <= alerta_d;
      estado_q  <= estado_d;
    end
  end

  assign ventilacion = vent_q;
  assign alarma      = alarma_q;
  assign alerta      = alerta_q;
  assign estado      = estado_q;
  assign tick        = tick_w;

endmodule
